// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding constants, instruction-format enum, encoder FSM states
// and an opcode-to-format lookup used by the instruction encoder slice.
package rv32i_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_J     = 7'b1101111;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT1,
        EMIT2
    } state_t;

    function automatic fmt_t fmt_of(input logic [6:0] opcode);
        fmt_t f;
        case (opcode)
            OP_R:                   f = FMT_R;
            OP_I, OP_LOAD, OP_JALR: f = FMT_I;
            OP_S:                   f = FMT_S;
            OP_B:                   f = FMT_B;
            OP_LUI, OP_AUIPC:       f = FMT_U;
            OP_J:                   f = FMT_J;
            default:                f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer. Places register, funct and immediate
// fields according to the format implied by the opcode and substitutes
// NOP_WORD (with err) for unknown opcodes. With STRICT_CHECK_EN defined,
// out-of-range or misaligned immediates are also replaced by NOP_WORD;
// otherwise immediates are silently truncated to their field width.
module instr_pack
    import rv32i_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP
) (
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    fmt_t        fmt;
    logic        is_shift;
    logic [11:0] imm_i;
    logic        range_ok;
    logic [31:0] word;

    assign fmt      = fmt_of(opcode);
    // SLLI / SRLI / SRAI: OP-IMM with funct3 001 or 101
    assign is_shift = (opcode == OP_I) && (funct3[1:0] == 2'b01);

    // I-type immediate field, with the shamt form for shifts
    always_comb begin
        if (is_shift) begin
            imm_i = {(funct3[2] && funct7[5]) ? 7'b0100000 : 7'b0000000, imm[4:0]};
        end else begin
            imm_i = imm[11:0];
        end
    end

    // Immediate range and alignment check for the selected format
    always_comb begin
        range_ok = 1'b1;
`ifdef STRICT_CHECK_EN
        case (fmt)
            FMT_I: begin
                if (is_shift) begin
                    range_ok = (imm[31:5] == '0);
                end else begin
                    range_ok = (&imm[31:11]) || !(|imm[31:11]);
                end
            end
            FMT_S:   range_ok = (&imm[31:11]) || !(|imm[31:11]);
            FMT_B:   range_ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
            FMT_J:   range_ok = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
            FMT_U:   range_ok = (imm[11:0] == '0);
            default: range_ok = 1'b1;
        endcase
`else
        range_ok = 1'b1;
`endif
    end

    // Field placement per instruction format
    always_comb begin
        word = NOP_WORD;
        case (fmt)
            FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   word = {imm_i, rs1, funct3, rd, opcode};
            FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U:   word = {imm[31:12], rd, opcode};
            FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: word = NOP_WORD;
        endcase
    end

    assign err   = (fmt == FMT_BAD) || !range_ok;
    assign instr = err ? NOP_WORD : word;

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with valid/ready handshakes on both sides.
// Encodes one request per word and expands the LI pseudo-instruction into
// LUI (+ ADDI when the low part is non-zero). Range checking of immediates
// is enabled by defining STRICT_CHECK_EN.
module instr_encoder
    import rv32i_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = 32'h0000_0013,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_li,
    input  logic [6:0]       req_opcode,
    input  logic [2:0]       req_funct3,
    input  logic [6:0]       req_funct7,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rs1,
    input  logic [4:0]       req_rs2,
    input  logic [31:0]      req_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic             out_last,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    state_t      state_nxt;

    logic        pend;
    logic [4:0]  li_rd;
    logic [11:0] li_lo;

    logic        accept;
    logic        handshake;
    logic        beat2;

    logic        li_small;
    logic        li_two;
    logic [19:0] li_hi;

    logic [6:0]  p_opcode;
    logic [2:0]  p_funct3;
    logic [6:0]  p_funct7;
    logic [4:0]  p_rd;
    logic [4:0]  p_rs1;
    logic [4:0]  p_rs2;
    logic [31:0] p_imm;
    logic [31:0] p_instr;
    logic        p_err;

    assign accept    = req_valid && req_ready;
    assign handshake = out_valid && out_ready;
    // pend is only ever set while in EMIT1, so this is the LI first-beat handoff
    assign beat2     = handshake && pend;

    // LI split: (imm + 0x800) >> 12 is the upper field plus the rounding carry of bit 11
    assign li_small = (&req_imm[31:11]) || !(|req_imm[31:11]);
    assign li_hi    = req_imm[31:12] + {19'b0, req_imm[11]};
    assign li_two   = !li_small && (req_imm[11:0] != '0);

    // Select packer fields: owed LI ADDI beat, LI first word, or a plain request
    always_comb begin
        p_opcode = req_opcode;
        p_funct3 = req_funct3;
        p_funct7 = req_funct7;
        p_rd     = req_rd;
        p_rs1    = req_rs1;
        p_rs2    = req_rs2;
        p_imm    = req_imm;
        if (pend) begin
            p_opcode = OP_I;
            p_funct3 = 3'b000;
            p_funct7 = '0;
            p_rd     = li_rd;
            p_rs1    = li_rd;
            p_rs2    = '0;
            p_imm    = {{20{li_lo[11]}}, li_lo};
        end else if (req_li) begin
            p_opcode = li_small ? OP_I : OP_LUI;
            p_funct3 = 3'b000;
            p_funct7 = '0;
            p_rd     = req_rd;
            p_rs1    = '0;
            p_rs2    = '0;
            p_imm    = li_small ? req_imm : {li_hi, 12'h000};
        end
    end

    instr_pack #(
        .NOP_WORD (NOP_WORD)
    ) u_pack (
        .opcode (p_opcode),
        .funct3 (p_funct3),
        .funct7 (p_funct7),
        .rd     (p_rd),
        .rs1    (p_rs1),
        .rs2    (p_rs2),
        .imm    (p_imm),
        .instr  (p_instr),
        .err    (p_err)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = EMIT1;
            end
            EMIT1: begin
                if (handshake) begin
                    if (pend)        state_nxt = EMIT2;
                    else if (accept) state_nxt = EMIT1;
                    else             state_nxt = IDLE;
                end
            end
            EMIT2: begin
                if (handshake) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs derived from state
    always_comb begin
        req_ready = 1'b0;
        out_valid = (state != IDLE);
        case (state)
            IDLE:    req_ready = 1'b1;
            EMIT1:   req_ready = out_ready && !pend;
            default: req_ready = 1'b0;
        endcase
    end

    // Output word register; loads only on accept or LI second beat, so it holds under stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_instr <= '0;
            out_err   <= 1'b0;
            out_last  <= 1'b0;
            pend      <= 1'b0;
            li_rd     <= '0;
            li_lo     <= '0;
        end else if (beat2) begin
            out_instr <= p_instr;
            out_err   <= p_err;
            out_last  <= 1'b1;
            pend      <= 1'b0;
        end else if (accept) begin
            out_instr <= p_instr;
            out_err   <= p_err;
            out_last  <= !(req_li && li_two);
            pend      <= req_li && li_two;
            li_rd     <= req_rd;
            li_lo     <= req_imm[11:0];
        end
    end

    // Count of handed-off words, wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count <= '0;
        end else if (handshake) begin
            out_count <= out_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed test-plan vectors plus
// randomized traffic scored against an arithmetic reference encoder.
module tb_instr_encoder;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_li;
    logic [6:0]       req_opcode;
    logic [2:0]       req_funct3;
    logic [6:0]       req_funct7;
    logic [4:0]       req_rd;
    logic [4:0]       req_rs1;
    logic [4:0]       req_rs2;
    logic [31:0]      req_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic             out_last;
    logic [CNT_W-1:0] out_count;

    always #5 clk = ~clk;

    instr_encoder #(
        .NOP_WORD (32'h0000_0013),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_li     (req_li),
        .req_opcode (req_opcode),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_err    (out_err),
        .out_last   (out_last),
        .out_count  (out_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic        last;
        logic        sole;
    } exp_t;

    exp_t        q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned mcnt  = 0;
    bit          strict;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Reference encoder: {err, word}, built arithmetically from the format rules
    function automatic logic [32:0] ref_enc(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [31:0] imm);
        longint          s;
        longint unsigned u, f, w;
        longint unsigned lop, lf3, lf7, lrd, lrs1, lrs2;
        bit              ok, bad;
        s    = longint'($signed(imm));
        u    = longint'(imm);
        lop  = longint'(op);
        lf3  = longint'(f3);
        lf7  = longint'(f7);
        lrd  = longint'(rd);
        lrs1 = longint'(rs1);
        lrs2 = longint'(rs2);
        ok   = 1'b1;
        bad  = 1'b0;
        w    = 0;
        case (op)
            7'h33: w = (lf7 << 25) | (lrs2 << 20) | (lrs1 << 15) | (lf3 << 12) | (lrd << 7) | lop;
            7'h13, 7'h03, 7'h67: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    ok = (u < 32);
                    f  = (u % 32) + ((f3 == 3'd5 && f7[5]) ? 64'h400 : 64'h0);
                end else begin
                    ok = (s >= -2048) && (s <= 2047);
                    f  = u % 4096;
                end
                w = (f << 20) | (lrs1 << 15) | (lf3 << 12) | (lrd << 7) | lop;
            end
            7'h23: begin
                ok = (s >= -2048) && (s <= 2047);
                f  = u % 4096;
                w  = ((f / 32) << 25) | (lrs2 << 20) | (lrs1 << 15) | (lf3 << 12) | ((f % 32) << 7) | lop;
            end
            7'h63: begin
                ok = (s >= -4096) && (s <= 4094) && (u % 2 == 0);
                f  = u % 8192;
                w  = ((f / 4096) << 31) | (((f / 32) % 64) << 25) | (lrs2 << 20) | (lrs1 << 15)
                   | (lf3 << 12) | (((f / 2) % 16) << 8) | (((f / 2048) % 2) << 7) | lop;
            end
            7'h37, 7'h17: begin
                ok = (u % 4096 == 0);
                w  = ((u / 4096) << 12) | (lrd << 7) | lop;
            end
            7'h6F: begin
                ok = (s >= -1048576) && (s <= 1048574) && (u % 2 == 0);
                f  = u % 2097152;
                w  = ((f / 1048576) << 31) | (((f / 2) % 1024) << 21) | (((f / 2048) % 2) << 20)
                   | (((f / 4096) % 256) << 12) | (lrd << 7) | lop;
            end
            default: bad = 1'b1;
        endcase
        if (bad || (strict && !ok)) return {1'b1, 32'h0000_0013};
        return {1'b0, w[31:0]};
    endfunction

    task automatic push_req(input logic li, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
        logic [32:0]     r;
        longint          s;
        longint unsigned hi, lo;
        longint          lo_s;
        bit              two;
        s = longint'($signed(imm));
        if (!li) begin
            r = ref_enc(op, f3, f7, rd, rs1, rs2, imm);
            q.push_back('{r[31:0], r[32], 1'b1, 1'b1});
        end else if (s >= -2048 && s <= 2047) begin
            r = ref_enc(7'h13, 3'd0, 7'd0, rd, 5'd0, 5'd0, imm);
            q.push_back('{r[31:0], r[32], 1'b1, 1'b1});
        end else begin
            hi   = ((longint'(imm) + 2048) / 4096) % 1048576;
            lo   = longint'(imm) % 4096;
            lo_s = (lo >= 2048) ? longint'(lo) - 4096 : longint'(lo);
            two  = (lo != 0);
            r = ref_enc(7'h37, 3'd0, 7'd0, rd, 5'd0, 5'd0, 32'(hi * 4096));
            q.push_back('{r[31:0], r[32], !two, !two});
            if (two) begin
                r = ref_enc(7'h13, 3'd0, 7'd0, rd, rd, 5'd0, 32'(lo_s));
                q.push_back('{r[31:0], r[32], 1'b1, 1'b0});
            end
        end
    endtask

    // One cycle: score the current outputs against the model, then pass the edge
    task automatic tick(output bit acc);
        bit exp_rdy, mhs;
        #1;
        exp_rdy = (q.size() == 0) || (out_ready && q.size() == 1 && q[0].sole);
        mhs     = (q.size() != 0) && out_ready;
        acc     = req_valid && exp_rdy;
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("out_count", 32'(out_count), mcnt & 32'h0000_FFFF);
        if (q.size() != 0) begin
            check("out_instr", out_instr, q[0].instr);
            check("out_err", 32'(out_err), 32'(q[0].err));
            check("out_last", 32'(out_last), 32'(q[0].last));
        end
        if (mhs) begin
            void'(q.pop_front());
            mcnt++;
        end
        if (acc) push_req(req_li, req_opcode, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, req_imm);
        @(negedge clk);
    endtask

    task automatic issue(input logic li, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        bit          a;
        int unsigned n;
        req_li     = li;
        req_opcode = op;
        req_funct3 = f3;
        req_funct7 = f7;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_imm    = imm;
        req_valid  = 1'b1;
        n = 0;
        do begin
            tick(a);
            n++;
        end while (!a && n < 64);
        if (!a) check("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        bit          a;
        int unsigned n;
        out_ready = 1'b1;
        req_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 64) begin
            tick(a);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
        tick(a);
    endtask

    function automatic logic [31:0] rand_imm();
        int edges[$] = '{-2048, 2047, 2048, -2049, 0, 31, 32, 4094, 4095, -4096, -4098,
                         1048574, 1048575, 1048576, -1048576, -1048578, 32'h12345FFF, 32'h00010000};
        case ($urandom_range(0, 5))
            0:       return 32'($urandom_range(0, 80)) - 32'd40;
            1:       return 32'(edges[$urandom_range(0, edges.size() - 1)]);
            2:       return 32'($urandom);
            3:       return 32'($urandom) & 32'hFFFF_F000;
            4:       return 32'($urandom_range(0, 63));
            default: return 32'($signed($urandom) >>> $urandom_range(8, 20));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          a;
        int unsigned c0;
        logic [6:0]  ops[$] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

`ifdef STRICT_CHECK_EN
        strict = 1'b1;
`else
        strict = 1'b0;
`endif
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_li     = 1'b0;
        req_opcode = '0;
        req_funct3 = '0;
        req_funct7 = '0;
        req_rd     = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        req_imm    = '0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ADDI x5,x0,-1 : valid one cycle after accept
        out_ready = 1'b1;
        issue(1'b0, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
        #1;
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_word", out_instr, 32'hFFF0_0293);
        check("addi_last", 32'(out_last), 32'd1);
        tick(a);

        // SRAI x1,x2,3
        issue(1'b0, 7'h13, 3'd5, 7'b0100000, 5'd1, 5'd2, 5'd0, 32'd3);
        #1;
        check("srai_word", out_instr, 32'h4031_5093);
        tick(a);

        // BEQ x1,x2,-8 and the misaligned imm=3 variant
        issue(1'b0, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
        #1;
        check("beq_word", out_instr, 32'hFE20_8CE3);
        tick(a);
        issue(1'b0, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        #1;
        check("beq_odd_word", out_instr, strict ? 32'h0000_0013 : 32'h0020_8163);
        check("beq_odd_err", 32'(out_err), strict ? 32'd1 : 32'd0);
        tick(a);

        // LI x10,0x12345FFF with stalls between beats
        c0 = mcnt;
        out_ready = 1'b0;
        issue(1'b1, 7'h00, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
        repeat (3) begin
            #1;
            check("li_b1_hold", out_instr, 32'h1234_6537);
            check("li_b1_ready", 32'(req_ready), 32'd0);
            tick(a);
        end
        out_ready = 1'b1;
        #1;
        check("li_b1_last", 32'(out_last), 32'd0);
        tick(a);
        out_ready = 1'b0;
        #1;
        check("li_b2_word", out_instr, 32'hFFF5_0513);
        check("li_b2_last", 32'(out_last), 32'd1);
        check("li_b2_ready", 32'(req_ready), 32'd0);
        tick(a);
        out_ready = 1'b1;
        tick(a);
        #1;
        check("li_count", 32'(out_count), (c0 + 32'd2) & 32'h0000_FFFF);
        tick(a);

        // LI x10,0x00010000 : single LUI
        issue(1'b1, 7'h00, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h0001_0000);
        #1;
        check("li_lui_word", out_instr, 32'h0001_0537);
        check("li_lui_last", 32'(out_last), 32'd1);
        tick(a);

        // Back-to-back ADDI at full throughput
        for (int i = 0; i < 4; i++) begin
            req_li     = 1'b0;
            req_opcode = 7'h13;
            req_funct3 = 3'd0;
            req_funct7 = 7'd0;
            req_rd     = 5'(i + 1);
            req_rs1    = 5'(i);
            req_rs2    = 5'd0;
            req_imm    = 32'(i * 3);
            req_valid  = 1'b1;
            #1;
            check("b2b_ready", 32'(req_ready), 32'd1);
            tick(a);
        end
        req_valid = 1'b0;
        drain();

        // Asynchronous reset while in EMIT2
        issue(1'b1, 7'h00, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
        tick(a);
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(out_count), 32'd0);
        q.delete();
        mcnt = 0;
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
        #1;
        check("arst_next_word", out_instr, 32'hFFF0_0293);
        tick(a);

        // Randomized traffic with random backpressure
        for (int k = 0; k < 800; k++) begin
            req_valid  = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 3) != 0);
            req_li     = ($urandom_range(0, 5) == 0);
            req_opcode = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, ops.size() - 1)];
            req_funct3 = 3'($urandom);
            req_funct7 = 7'($urandom);
            req_rd     = 5'($urandom);
            req_rs1    = 5'($urandom);
            req_rs2    = 5'($urandom);
            req_imm    = rand_imm();
            tick(a);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Builds RV32I instruction words from decoded fields. It is the inverse of the immediate-generation/decode path: opcode, funct, register and signed-immediate fields go in, and a packed 32-bit instruction comes out. It feeds the debug/boot instruction injector and the self-test sequencer, which push encoded words into instruction memory or the fetch stage. It also expands the LI pseudo-instruction into one or two words.

Parameters:
NOP_WORD, 32'h0000_0013, word emitted in place of an invalid or unencodable request (ADDI x0,x0,0)
CNT_W, 16, width of the emitted-instruction counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when high with req_valid
req_li  in  1  LI pseudo-instruction; only req_rd and req_imm used
req_opcode  in  7  RV32I major opcode
req_funct3  in  3  funct3
req_funct7  in  7  funct7 (R-type; bit 5 selects SRAI)
req_rd  in  5  destination register
req_rs1  in  5  source register 1
req_rs2  in  5  source register 2
req_imm  in  32  signed immediate value (byte offset for B/J; full value with low 12 bits zero for U)
out_valid  out  1  instruction word present
out_ready  in  1  consumer accepts when high with out_valid
out_instr  out  32  encoded instruction
out_err  out  1  word replaced by NOP_WORD (invalid opcode or out-of-range immediate)
out_last  out  1  final word of the current request
out_count  out  CNT_W  number of words handed off, wraps at 2^CNT_W

Behaviour:
- One clock (clk). Asynchronous active-high reset rst. On reset:
  - out_valid=0, out_instr=0, out_err=0, out_last=0, out_count=0, state=IDLE.
  - Any in-flight LI second beat is dropped.
- FSM states: IDLE, EMIT1, EMIT2.
  - IDLE: req_ready=1.
  - IDLE, request accepted: register the encoded first word. Go to EMIT1. out_valid is high the next cycle (latency 1).
  - EMIT1, handshake, no second word pending: if req_valid is also accepted in the same cycle, stay in EMIT1 with the new word. Otherwise go to IDLE. req_ready = out_ready in EMIT1, so full throughput is sustained.
  - EMIT1, LI second word pending: req_ready=0. On handshake go to EMIT2.
  - EMIT2: req_ready=0. On handshake go to IDLE.
- Output hold: out_instr, out_err and out_last stay stable while out_valid && !out_ready.
- Formats are selected by opcode:
  - R (0110011)
  - I (0010011, 0000011, 1100111)
  - S (0100011)
  - B (1100011)
  - U (0110111, 0010111)
  - J (1101111)
  - Any other opcode gives NOP_WORD with out_err=1.
- Shift-immediate special case (OP-IMM with funct3 001 or 101):
  - imm[4:0] = shamt.
  - imm[11:5] = 0100000 for funct3=101 with req_funct7[5]=1, otherwise 0000000.
- Immediate bit placement:
  - I: imm[11:0] at [31:20].
  - S: imm[11:5] at [31:25], imm[4:0] at [11:7].
  - B: imm[12] at [31], imm[10:5] at [30:25], imm[4:1] at [11:8], imm[11] at [7].
  - U: imm[31:12] at [31:12].
  - J: imm[20] at [31], imm[10:1] at [30:21], imm[11] at [20], imm[19:12] at [19:12].
- Range rules:
  - I/S: -2048..2047.
  - Shift: 0..31.
  - B: -4096..4094, even.
  - J: -1048576..1048574, even.
  - U: imm[11:0]==0.
- LI expansion:
  - If req_imm is in -2048..2047: single ADDI rd,x0,imm, out_last=1.
  - Otherwise: lo = sext(imm[11:0]), hi = (imm + 0x800) >> 12, mod 2^20.
    - Emit LUI rd,hi.
    - If lo!=0, then emit ADDI rd,rd,lo. out_last=1 only on the final word.
- out_count increments on every out_valid && out_ready handshake.

Optional Feature:
STRICT_CHECK_EN
- Defined: range and alignment violations replace the word with NOP_WORD and set out_err=1.
- Undefined: immediates are truncated to field width with no check. out_err is raised only for invalid opcodes.

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_JALR, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_J)
  - format enum
  - NOP constant
- Sub-module instr_pack: combinational field packer plus range check, driven by the FSM for both normal and LI beats.

Test Plan:
- ADDI x5,x0,-1 (opcode 0010011, f3 000, imm -1) -> out_instr=0xFFF00293, out_err=0, out_last=1, valid one cycle after accept.
- SRAI x1,x2,3 (f3 101, funct7 0100000) -> 0x40315093.
- BEQ x1,x2,-8 -> 0xFE208CE3. Same request with imm=3 under STRICT_CHECK_EN -> 0x00000013 with out_err=1.
- LI x10,0x12345FFF with out_ready low for 3 cycles between beats:
  - beat 1: 0x12346537, held stable while stalled
  - beat 2: 0xFFF50513 with out_last=1
  - req_ready=0 throughout
  - out_count +2
- LI x10,0x00010000 -> single word 0x00010537 with out_last=1. Back-to-back ADDI requests with out_ready=1 give one word per cycle.
- Assert rst while in EMIT2 -> out_valid=0 immediately (asynchronous), out_count=0, next request encodes normally.
